// File: rtl/wave_synth.sv
// DDS phase-to-amplitude back end: sine (quarter-wave LUT), triangle, square, PWM.
// Optional AMP_SCALE_EN adds amp_word and a fourth amplitude-scaling stage.
module wave_synth #(
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned OUT_W   = 12,
  parameter int unsigned LUT_AW  = 6
) (
  input  logic               clk_100m,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [1:0]         wave_word,
  input  logic [6:0]         pwm_word,
`ifdef AMP_SCALE_EN
  input  logic [3:0]         amp_word,
`endif
  input  logic [PHASE_W-1:0] phase_in,
  output logic [OUT_W-1:0]   wave_out,
  output logic               out_valid,
  output logic               wrap
);

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'b00,
    WAVE_TRI    = 2'b01,
    WAVE_SQUARE = 2'b10,
    WAVE_PWM    = 2'b11
  } wave_e;

  localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

  // Q[k] = round(2047*sin(pi/2*(k+0.5)/64))
  localparam logic [OUT_W-2:0] SINE_Q [2**LUT_AW] = '{
    11'd25,   11'd75,   11'd126,  11'd176,  11'd226,  11'd275,  11'd325,  11'd375,
    11'd424,  11'd473,  11'd522,  11'd570,  11'd618,  11'd666,  11'd713,  11'd760,
    11'd807,  11'd852,  11'd898,  11'd943,  11'd987,  11'd1031, 11'd1074, 11'd1116,
    11'd1158, 11'd1199, 11'd1239, 11'd1279, 11'd1318, 11'd1356, 11'd1393, 11'd1430,
    11'd1465, 11'd1500, 11'd1533, 11'd1566, 11'd1598, 11'd1629, 11'd1659, 11'd1688,
    11'd1716, 11'd1743, 11'd1769, 11'd1793, 11'd1817, 11'd1840, 11'd1861, 11'd1881,
    11'd1901, 11'd1919, 11'd1936, 11'd1951, 11'd1966, 11'd1979, 11'd1992, 11'd2003,
    11'd2012, 11'd2021, 11'd2028, 11'd2035, 11'd2039, 11'd2043, 11'd2046, 11'd2047
  };

  logic               wrap_det, ctrl_load;
  logic [1:0]         quad;
  logic [LUT_AW-1:0]  idx, lut_addr;

  logic [PHASE_W-1:0] phase_prev_d, phase_prev_q;
  logic               en_prev_d, en_prev_q;
  wave_e              wave_act_d, wave_act_q;
  logic [6:0]         pwm_act_d, pwm_act_q;

  logic               s1_valid_d, s1_valid_q, s1_wrap_d, s1_wrap_q;
  logic [PHASE_W-4:0] s1_ph_d, s1_ph_q;
  wave_e              s1_wave_d, s1_wave_q;
  logic [6:0]         s1_pwm_d, s1_pwm_q;

  logic               s2_valid_d, s2_valid_q, s2_wrap_d, s2_wrap_q;
  logic               s2_sine_d, s2_sine_q, s2_neg_d, s2_neg_q;
  logic [OUT_W-2:0]   s2_lut_d, s2_lut_q;
  logic [OUT_W-1:0]   s2_raw_d, s2_raw_q;

  logic               s3_valid_d, s3_valid_q, s3_wrap_d, s3_wrap_q;
  logic [OUT_W-1:0]   s3_sample_d, s3_sample_q;

`ifdef AMP_SCALE_EN
  logic [3:0]         amp_act_d, amp_act_q, s1_amp_d, s1_amp_q;
  logic [3:0]         s2_amp_d, s2_amp_q, s3_amp_d, s3_amp_q;
  logic signed [OUT_W:0]   amp_diff;
  logic signed [5:0]       amp_gain;
  logic signed [OUT_W+6:0] amp_prod, amp_shift;
  logic               s4_valid_d, s4_valid_q, s4_wrap_d, s4_wrap_q;
  logic [OUT_W-1:0]   s4_sample_d, s4_sample_q;
`endif

  always_comb begin
    // A wrap or the first enabled cycle loads the control words for this very sample.
    wrap_det     = enable && (phase_in < phase_prev_q);
    ctrl_load    = enable && (wrap_det || !en_prev_q);
    phase_prev_d = enable ? phase_in : phase_prev_q;
    en_prev_d    = enable;
    wave_act_d   = ctrl_load ? wave_e'(wave_word) : wave_act_q;
    pwm_act_d    = ctrl_load ? pwm_word : pwm_act_q;

    s1_valid_d = enable;
    s1_wrap_d  = wrap_det;
    s1_ph_d    = phase_in[PHASE_W-1:3];
    s1_wave_d  = wave_act_d;
    s1_pwm_d   = pwm_act_d;

    quad       = s1_ph_q[12:11];
    idx        = s1_ph_q[10:5];
    lut_addr   = quad[0] ? ~idx : idx;
    s2_lut_d   = SINE_Q[lut_addr];
    s2_neg_d   = quad[1];
    s2_sine_d  = (s1_wave_q == WAVE_SINE);
    s2_valid_d = s1_valid_q;
    s2_wrap_d  = s1_wrap_q;
    s2_raw_d   = MID;
    case (s1_wave_q)
      WAVE_TRI:    s2_raw_d = s1_ph_q[12] ? ~s1_ph_q[11:0] : s1_ph_q[11:0];
      WAVE_SQUARE: s2_raw_d = s1_ph_q[12] ? '0 : '1;
      WAVE_PWM:    s2_raw_d = (s1_ph_q[12:6] < s1_pwm_q) ? '1 : '0;
      WAVE_SINE:   s2_raw_d = MID;
    endcase

    s3_valid_d  = s2_valid_q;
    s3_wrap_d   = s2_wrap_q;
    s3_sample_d = MID;
    if (s2_valid_q) begin
      if (!s2_sine_q)    s3_sample_d = s2_raw_q;
      else if (s2_neg_q) s3_sample_d = (MID - 1'b1) - {1'b0, s2_lut_q};
      else               s3_sample_d = MID + {1'b0, s2_lut_q};
    end

`ifdef AMP_SCALE_EN
    amp_act_d   = ctrl_load ? amp_word : amp_act_q;
    s1_amp_d    = amp_act_d;
    s2_amp_d    = s1_amp_q;
    s3_amp_d    = s2_amp_q;
    amp_diff    = $signed({1'b0, s3_sample_q}) - $signed({1'b0, MID});
    amp_gain    = $signed({2'b00, s3_amp_q}) + 6'sd1;
    amp_prod    = amp_diff * amp_gain;
    amp_shift   = amp_prod >>> 4;
    s4_valid_d  = s3_valid_q;
    s4_wrap_d   = s3_wrap_q;
    s4_sample_d = s3_valid_q ? OUT_W'(amp_shift + $signed({1'b0, MID})) : MID;
`endif
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      phase_prev_q <= '0;
      en_prev_q    <= 1'b0;
      wave_act_q   <= WAVE_SINE;
      pwm_act_q    <= '0;
      s1_valid_q   <= 1'b0;
      s1_wrap_q    <= 1'b0;
      s1_ph_q      <= '0;
      s1_wave_q    <= WAVE_SINE;
      s1_pwm_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_wrap_q    <= 1'b0;
      s2_sine_q    <= 1'b0;
      s2_neg_q     <= 1'b0;
      s2_lut_q     <= '0;
      s2_raw_q     <= MID;
      s3_valid_q   <= 1'b0;
      s3_wrap_q    <= 1'b0;
      s3_sample_q  <= MID;
`ifdef AMP_SCALE_EN
      amp_act_q    <= '0;
      s1_amp_q     <= '0;
      s2_amp_q     <= '0;
      s3_amp_q     <= '0;
      s4_valid_q   <= 1'b0;
      s4_wrap_q    <= 1'b0;
      s4_sample_q  <= MID;
`endif
    end else begin
      phase_prev_q <= phase_prev_d;
      en_prev_q    <= en_prev_d;
      wave_act_q   <= wave_act_d;
      pwm_act_q    <= pwm_act_d;
      s1_valid_q   <= s1_valid_d;
      s1_wrap_q    <= s1_wrap_d;
      s1_ph_q      <= s1_ph_d;
      s1_wave_q    <= s1_wave_d;
      s1_pwm_q     <= s1_pwm_d;
      s2_valid_q   <= s2_valid_d;
      s2_wrap_q    <= s2_wrap_d;
      s2_sine_q    <= s2_sine_d;
      s2_neg_q     <= s2_neg_d;
      s2_lut_q     <= s2_lut_d;
      s2_raw_q     <= s2_raw_d;
      s3_valid_q   <= s3_valid_d;
      s3_wrap_q    <= s3_wrap_d;
      s3_sample_q  <= s3_sample_d;
`ifdef AMP_SCALE_EN
      amp_act_q    <= amp_act_d;
      s1_amp_q     <= s1_amp_d;
      s2_amp_q     <= s2_amp_d;
      s3_amp_q     <= s3_amp_d;
      s4_valid_q   <= s4_valid_d;
      s4_wrap_q    <= s4_wrap_d;
      s4_sample_q  <= s4_sample_d;
`endif
    end
  end

`ifdef AMP_SCALE_EN
  assign wave_out  = s4_sample_q;
  assign out_valid = s4_valid_q;
  assign wrap      = s4_wrap_q;
`else
  assign wave_out  = s3_sample_q;
  assign out_valid = s3_valid_q;
  assign wrap      = s3_wrap_q;
`endif

endmodule

// File: tb/tb_wave_synth.sv
// Scoreboard bench for wave_synth: stimulus pushes reference samples, a negedge monitor pops and compares.
module tb_wave_synth;

`ifdef AMP_SCALE_EN
  localparam int unsigned LAT = 4;
  logic [3:0] amp_word = 4'd15;
`else
  localparam int unsigned LAT = 3;
`endif

  logic        clk_100m = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  wave_word = '0;
  logic [6:0]  pwm_word = '0;
  logic [15:0] phase_in = '0;
  logic [11:0] wave_out;
  logic        out_valid;
  logic        wrap;

  always #5 clk_100m = ~clk_100m;

  wave_synth #(.PHASE_W(16), .OUT_W(12), .LUT_AW(6)) dut (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .enable   (enable),
    .wave_word(wave_word),
    .pwm_word (pwm_word),
`ifdef AMP_SCALE_EN
    .amp_word (amp_word),
`endif
    .phase_in (phase_in),
    .wave_out (wave_out),
    .out_valid(out_valid),
    .wrap     (wrap)
  );

  typedef struct {
    int unsigned due;
    logic [11:0] val;
    logic        wr;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          qtab[64];

  // Reference-model state: what the spec says is remembered between samples.
  int          m_prev_phase = 0;
  bit          m_prev_en = 1'b0;
  int          m_wave = 0;
  int          m_pwm = 0;

  always @(posedge clk_100m) cyc <= cyc + 1;

  function automatic logic [11:0] ref_sample(int ph, int w, int d);
    int quad, idx, t;
    quad = ph / 16384;
    idx  = (ph / 256) % 64;
    case (w)
      0: case (quad)
           0: return 12'(2048 + qtab[idx]);
           1: return 12'(2048 + qtab[63 - idx]);
           2: return 12'(2047 - qtab[idx]);
           default: return 12'(2047 - qtab[63 - idx]);
         endcase
      1: begin
           t = (ph / 8) % 4096;
           return 12'((ph < 32768) ? t : 4095 - t);
         end
      2: return (ph < 32768) ? 12'd4095 : 12'd0;
      default: return ((ph / 512) < d) ? 12'd4095 : 12'd0;
    endcase
  endfunction

  task automatic model_reset();
    sb.delete();
    m_prev_phase = 0;
    m_prev_en    = 1'b0;
    m_wave       = 0;
    m_pwm        = 0;
  endtask

  task automatic drive(input bit en, input int w, input int d, input int ph);
    exp_t e;
    bit   wr;
    enable    = en;
    wave_word = w[1:0];
    pwm_word  = d[6:0];
    phase_in  = ph[15:0];
    if (rst_n) begin
      if (en) begin
        wr = (ph < m_prev_phase);
        if (wr || !m_prev_en) begin
          m_wave = w;
          m_pwm  = d;
        end
        e.due = cyc + LAT;
        e.val = ref_sample(ph, m_wave, m_pwm);
        e.wr  = wr;
        sb.push_back(e);
        m_prev_phase = ph;
      end
      m_prev_en = en;
    end
    @(posedge clk_100m);
    #1;
  endtask

  logic [13:0] mon_act, mon_req;
  exp_t        mon_e;
  always @(negedge clk_100m) begin
    mon_act = {out_valid, wrap, wave_out};
    if (!rst_n) begin
      mon_req = {2'b00, 12'd2048};
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      mon_e   = sb.pop_front();
      mon_req = {1'b1, mon_e.wr, mon_e.val};
    end else begin
      mon_req = {2'b00, 12'd2048};
    end
    total++;
    if (mon_act !== mon_req) begin
      bad++;
      $display("FAIL sample cyc=%0d rst_n=%b got valid=%b wrap=%b out=%0d want valid=%b wrap=%b out=%0d",
               cyc, rst_n, mon_act[13], mon_act[12], mon_act[11:0],
               mon_req[13], mon_req[12], mon_req[11:0]);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ph, w, d;
    bit en;
    for (int k = 0; k < 64; k++)
      qtab[k] = $rtoi(2047.0 * $sin(3.14159265358979 / 2.0 * (k + 0.5) / 64.0) + 0.5);

    // Reset held with enable and a ramping phase.
    @(posedge clk_100m); #1;
    for (int i = 0; i < 4; i++) drive(1'b1, 0, 0, i * 256);
    rst_n = 1'b1;

    // Sine corners.
    drive(1'b1, 0, 0, 16'h0000);
    drive(1'b1, 0, 0, 16'h3F00);
    drive(1'b1, 0, 0, 16'h4000);
    drive(1'b1, 0, 0, 16'h8000);
    drive(1'b1, 0, 0, 16'hC000);

    // Triangle then square, each selected at a wrap.
    drive(1'b1, 1, 0, 16'h0000);
    drive(1'b1, 1, 0, 16'h7FF8);
    drive(1'b1, 1, 0, 16'h8000);
    drive(1'b1, 1, 0, 16'hFFF8);
    drive(1'b1, 2, 0, 16'h7FFF);
    drive(1'b1, 2, 0, 16'h8000);

    // PWM duty 32/128, then duty 0.
    for (int i = 0; i < 256; i++) drive(1'b1, 3, 32, i * 256);
    for (int i = 0; i < 256; i++) drive(1'b1, 3, 0, i * 256);

    // Mid-period switch to square only takes effect after the wrap.
    for (int i = 0; i < 256; i++) drive(1'b1, (i >= 'h60) ? 2 : 0, 0, i * 256);
    for (int i = 0; i < 4; i++) drive(1'b1, 2, 0, i * 256);

    // Enable drop for 5 cycles with new words presented; latched on re-enable.
    for (int i = 4; i < 9; i++) drive(1'b0, 1, 0, i * 256);
    for (int i = 9; i < 20; i++) drive(1'b1, 1, 0, i * 256);

    // Randomized run: gaps, jumps and mid-period word changes.
    ph = 20 * 256; w = 1; d = 64;
    for (int i = 0; i < 2000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) w = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) d = $urandom_range(0, 127);
      if ($urandom_range(0, 49) == 0) ph = $urandom_range(0, 65535);
      else ph = (ph + $urandom_range(0, 2047)) % 65536;
      drive(en, w, d, ph);
    end

    // Asynchronous reset in the middle of a run.
    for (int i = 0; i < 3; i++) drive(1'b1, 3, 100, i * 4096);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) drive(1'b1, 3, 100, i * 4096);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) drive(1'b1, 3, 100, i * 4096);

    for (int i = 0; i < int'(LAT) + 2; i++) drive(1'b0, 0, 0, 0);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected samples never appeared, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
